// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, word-wide memory (asynchronous read, single write
//   enable, no byte enables) between the instruction-fetch port and the
//   load/store data port. Data requests win by default. A fetch that has
//   lost arbitration STARVE_LIMIT consecutive times is forced to win.
//   Sub-word stores are done as a read-modify-write: the grant cycle reads
//   the word, and the following RMW_WR cycle writes back the merged word.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   if_req/if_addr    fetch request and byte address (held until if_gnt)
//   if_gnt            fetch accepted this cycle
//   if_rvalid/rdata   fetch response, one cycle after if_gnt
//   d_req/d_we/d_addr/d_wdata/d_be
//                     data request (held until d_gnt); d_be applies to stores
//   d_gnt             data request accepted this cycle
//   d_rvalid/d_rdata  load response, one cycle after d_gnt
//   d_ack             store committed (or dropped for d_be == 0) this cycle
//   busy              high during the RMW write-back cycle
//   mem_addr/mem_wdata/mem_rw/mem_rdata
//                     memory interface; mem_rdata is combinational from mem_addr

module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [31:0]           if_rdata,

  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  input  logic [3:0]            d_be,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [31:0]           d_rdata,
  output logic                  d_ack,
  output logic                  busy,

  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_rw,
  input  logic [31:0]           mem_rdata
);

  localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

  typedef enum logic {
    IDLE,
    RMW_WR
  } state_t;

  state_t                state;
  logic [CW-1:0]         starve_cnt;
  logic [ADDR_WIDTH-1:0] rmw_addr;
  logic [31:0]           rmw_data;

  logic                  in_idle;
  logic                  in_rmw;
  logic                  fetch_win;
  logic                  data_win;
  logic                  load_gnt;
  logic                  store_full;
  logic                  store_sub;
  logic                  store_none;
  logic [31:0]           merged;

  // Grants, memory controls and d_ack must respond in the same cycle as the
  // request because the memory read is asynchronous, so they are decoded
  // from the registered state. Gating with reset forces every output low
  // the moment reset rises, regardless of the request inputs.
  always_comb begin
    in_idle    = (state == IDLE) && !reset;
    in_rmw     = (state == RMW_WR) && !reset;

    fetch_win  = in_idle && if_req && (!d_req || (starve_cnt == STARVE_MAX));
    data_win   = in_idle && d_req && !fetch_win;

    load_gnt   = data_win && !d_we;
    store_full = data_win && d_we && (d_be == 4'b1111);
    store_none = data_win && d_we && (d_be == 4'b0000);
    store_sub  = data_win && d_we && !store_full && !store_none;

    merged = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      merged[8*i +: 8] = d_be[i] ? d_wdata[8*i +: 8] : mem_rdata[8*i +: 8];
    end

    if_gnt    = fetch_win;
    d_gnt     = data_win;
    busy      = in_rmw;
    d_ack     = store_full || store_none || in_rmw;
    mem_rw    = store_full || in_rmw;
    mem_wdata = in_rmw ? rmw_data : d_wdata;

    if (in_rmw) begin
      mem_addr = rmw_addr;
    end else if (fetch_win) begin
      mem_addr = if_addr;
    end else begin
      mem_addr = d_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      rmw_addr   <= '0;
      rmw_data   <= '0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      d_rvalid   <= 1'b0;
      d_rdata    <= '0;
    end else begin
      if_rvalid <= fetch_win;
      if (fetch_win) begin
        if_rdata <= mem_rdata;
      end

      d_rvalid <= load_gnt;
      if (load_gnt) begin
        d_rdata <= mem_rdata;
      end

      // Counts every cycle a pending fetch is passed over, including the
      // RMW write-back cycle where no grant is possible at all.
      if (!if_req || fetch_win) begin
        starve_cnt <= '0;
      end else if (starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (store_sub) begin
            state    <= RMW_WR;
            rmw_addr <= d_addr;
            rmw_data <= merged;
          end
        end
        RMW_WR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned AW    = 32;
  localparam int unsigned LIMIT = 4;

  logic          clk;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic [3:0]    d_be;
  logic          d_gnt;
  logic          d_rvalid;
  logic [31:0]   d_rdata;
  logic          d_ack;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_rw;
  logic [31:0]   mem_rdata;

  int unsigned errors;
  int unsigned checks;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic [7:0]  mem_idx;

  mem_port_arbiter #(
    .ADDR_WIDTH  (AW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_be     (d_be),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .d_ack    (d_ack),
    .busy     (busy),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rw   (mem_rw),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int unsigned i);
    case (i)
      32'h10:  return 32'h1234_5678;
      32'h40:  return 32'h1122_3344;
      32'h80:  return 32'hAABB_CCDD;
      default: return (i * 32'h0103_0507) ^ 32'h5A5A_0000;
    endcase
  endfunction

  function automatic logic [31:0] merge_bytes(logic [31:0] old_w, logic [31:0] new_w,
                                              logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (new_w & mask) | (old_w & ~mask);
  endfunction

  // Memory instance stand-in: asynchronous read, synchronous write.
  always_comb mem_idx = 8'((mem_addr & 32'hFFFF_FFFC) >> 2);
  assign mem_rdata = mem[mem_idx];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_rw) mem[mem_idx] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_next();
    @(posedge clk);
    #1;
  endtask

  // One data-port transaction with fetch idle: grant is expected immediately.
  task automatic data_txn(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
    logic [7:0]  w;
    logic [31:0] exp_word;
    w = 8'(addr >> 2);
    drive_next();
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_be = be;
    @(negedge clk);
    chk("rnd_d_gnt", {31'b0, d_gnt}, 32'd1);
    if (we && be == 4'b1111) begin
      chk("rnd_full_ack_rw", {30'b0, d_ack, mem_rw}, 32'd3);
    end else if (we && be == 4'b0000) begin
      chk("rnd_zero_ack_rw", {30'b0, d_ack, mem_rw}, 32'd2);
    end else begin
      chk("rnd_grant_ack_rw", {30'b0, d_ack, mem_rw}, 32'd0);
    end
    drive_next();
    d_req = 1'b0;
    @(negedge clk);
    if (!we) begin
      chk("rnd_load_data", d_rdata, ref_mem[w]);
      chk("rnd_load_valid", {31'b0, d_rvalid}, 32'd1);
    end else if (be != 4'b1111 && be != 4'b0000) begin
      exp_word = merge_bytes(ref_mem[w], wdata, be);
      chk("rnd_rmw_flags", {29'b0, busy, d_ack, mem_rw}, 32'd7);
      chk("rnd_rmw_wdata", mem_wdata, exp_word);
    end else begin
      chk("rnd_store_busy", {31'b0, busy}, 32'd0);
    end
    if (we) ref_mem[w] = merge_bytes(ref_mem[w], wdata, be);
  endtask

  task automatic fetch_txn(input logic [31:0] addr);
    drive_next();
    if_req = 1'b1; if_addr = addr;
    @(negedge clk);
    chk("rnd_if_gnt", {31'b0, if_gnt}, 32'd1);
    drive_next();
    if_req = 1'b0;
    @(negedge clk);
    chk("rnd_if_rvalid", {31'b0, if_rvalid}, 32'd1);
    chk("rnd_if_rdata", if_rdata, ref_mem[8'(addr >> 2)]);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned losses;
    logic        exp_fetch;
    errors = 0;
    checks = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_flags", {23'b0, if_gnt, d_gnt, if_rvalid, d_rvalid, d_ack, busy, mem_rw, 2'b0},
        32'd0);
    chk("reset_rdata", if_rdata | d_rdata, 32'd0);
    reset = 1'b0;

    // Load from 0x100.
    drive_next();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    @(negedge clk);
    chk("load_gnt_rw", {30'b0, d_gnt, mem_rw}, 32'd2);
    drive_next();
    d_req = 1'b0;
    @(negedge clk);
    chk("load_rvalid", {30'b0, d_rvalid, mem_rw}, 32'd2);
    chk("load_rdata", d_rdata, 32'h1122_3344);
    drive_next();
    @(negedge clk);
    chk("load_rvalid_pulse", {31'b0, d_rvalid}, 32'd0);

    // Sub-word store to 0x202, lane 2.
    drive_next();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h202; d_wdata = 32'h00EE_0000; d_be = 4'b0100;
    @(negedge clk);
    chk("sub_grant", {28'b0, d_gnt, mem_rw, d_ack, busy}, 32'b1000);
    drive_next();
    d_req = 1'b0;
    @(negedge clk);
    chk("sub_rmw_flags", {28'b0, d_gnt, mem_rw, d_ack, busy}, 32'b0111);
    chk("sub_rmw_wdata", mem_wdata, 32'hAAEE_CCDD);
    chk("sub_rmw_addr", mem_addr, 32'h202);
    ref_mem[8'h80] = 32'hAAEE_CCDD;
    data_txn(1'b0, 32'h200, 32'h0, 4'h0);

    // Full-word store to 0x300.
    drive_next();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'hDEAD_BEEF; d_be = 4'b1111;
    @(negedge clk);
    chk("full_flags", {28'b0, d_gnt, mem_rw, d_ack, busy}, 32'b1110);
    chk("full_wdata", mem_wdata, 32'hDEAD_BEEF);
    drive_next();
    d_req = 1'b0;
    @(negedge clk);
    chk("full_no_busy", {30'b0, busy, mem_rw}, 32'd0);
    ref_mem[8'hC0] = 32'hDEAD_BEEF;
    data_txn(1'b0, 32'h300, 32'h0, 4'h0);

    // Both requesters held: fetch wins after LIMIT consecutive losses.
    drive_next();
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    losses = 0;
    for (int c = 0; c < 10; c++) begin
      exp_fetch = (losses == LIMIT);
      losses = exp_fetch ? 0 : losses + 1;
      @(negedge clk);
      chk($sformatf("starve_seq_%0d", c), {30'b0, if_gnt, d_gnt},
          exp_fetch ? 32'b10 : 32'b01);
      drive_next();
    end
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("starve_last_if_rdata", if_rdata, ref_mem[8'h40]);

    // Fetch raised alongside a sub-word store: waits out RMW_WR.
    drive_next();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h204; d_wdata = 32'h0000_00AB; d_be = 4'b0001;
    if_req = 1'b1; if_addr = 32'h204;
    @(negedge clk);
    chk("rmw_fetch_grant", {30'b0, if_gnt, d_gnt}, 32'b01);
    drive_next();
    d_req = 1'b0;
    @(negedge clk);
    chk("rmw_fetch_wait", {29'b0, if_gnt, busy, d_ack}, 32'b011);
    ref_mem[8'h81] = merge_bytes(ref_mem[8'h81], 32'h0000_00AB, 4'b0001);
    drive_next();
    @(negedge clk);
    chk("rmw_fetch_after", {30'b0, if_gnt, busy}, 32'b10);
    drive_next();
    if_req = 1'b0;
    @(negedge clk);
    chk("rmw_fetch_rvalid", {31'b0, if_rvalid}, 32'd1);
    chk("rmw_fetch_rdata", if_rdata, ref_mem[8'h81]);

    // Reset pulsed in the middle of RMW_WR.
    drive_next();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h0000_00FF; d_be = 4'b0001;
    @(negedge clk);
    chk("rst_rmw_grant", {31'b0, d_gnt}, 32'd1);
    drive_next();
    d_req = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("rst_rmw_outputs", {27'b0, d_ack, busy, mem_rw, if_rvalid, d_rvalid}, 32'd0);
    #1;
    reset = 1'b0;
    data_txn(1'b0, 32'h40, 32'h0, 4'h0);

    // Random traffic, one requester at a time, against the reference memory.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] addr;
      addr = 32'h400 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) begin
        fetch_txn(addr);
      end else begin
        logic [3:0] be;
        case ($urandom_range(0, 5))
          0:       be = 4'b1111;
          1:       be = 4'b0000;
          default: be = 4'($urandom_range(1, 14));
        endcase
        data_txn(1'($urandom_range(0, 1)), addr, $urandom, be);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port, word-wide unified memory between the instruction-fetch requester and the load/store data requester.
- The memory has an asynchronous read, one write-enable (mem_rw) and no byte enables. This block therefore sequences sub-word stores as read-modify-write (RMW).
- Sits between the core's fetch and memory stages and the memory instance. It registers read responses and arbitrates with data-first priority plus a starvation guard for fetch.

Parameters:
- ADDR_WIDTH, 32, byte-address width of all address ports.
- STARVE_LIMIT, 4, consecutive cycles a pending fetch may lose arbitration before it is forced to win.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- if_req  input  1  fetch request; held with if_addr until if_gnt.
- if_addr  input  ADDR_WIDTH  fetch byte address; bits [1:0] ignored.
- if_gnt  output  1  fetch accepted this cycle.
- if_rvalid  output  1  fetch data valid (one cycle after if_gnt).
- if_rdata  output  32  fetched word.
- d_req  input  1  data request; held with d_we/d_addr/d_wdata/d_be until d_gnt.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  ADDR_WIDTH  data byte address; bits [1:0] ignored.
- d_wdata  input  32  store data, already lane-aligned.
- d_be  input  4  byte enables for stores; ignored for loads.
- d_gnt  output  1  data request accepted this cycle.
- d_rvalid  output  1  load data valid (one cycle after d_gnt).
- d_rdata  output  32  loaded word.
- d_ack  output  1  store committed to memory this cycle.
- busy  output  1  high while in RMW_WR.
- mem_addr  output  ADDR_WIDTH  address to memory.
- mem_wdata  output  32  write data to memory.
- mem_rw  output  1  memory write enable.
- mem_rdata  input  32  memory asynchronous read data.

Behaviour:
- Reset (async) values: state=IDLE, starve counter=0, if_gnt=0, d_gnt=0, if_rvalid=0, d_rvalid=0, d_ack=0, busy=0, mem_rw=0, if_rdata=0, d_rdata=0.
- States: IDLE and RMW_WR.
- IDLE arbitration, one grant per cycle:
  - Data wins by default.
  - Fetch wins when only if_req is high, or when both are high and starve counter == STARVE_LIMIT.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) each IDLE or RMW_WR cycle in which if_req=1 and fetch is not granted.
  - Clears on if_gnt, or whenever if_req=0.
- Fetch grant (IDLE):
  - mem_addr=if_addr, mem_rw=0, if_gnt=1.
  - Next cycle: if_rvalid=1, if_rdata = registered mem_rdata.
- Load grant (IDLE):
  - mem_addr=d_addr, mem_rw=0, d_gnt=1.
  - Next cycle: d_rvalid=1, d_rdata = registered mem_rdata.
- Full-word store (d_be=4'b1111):
  - mem_addr=d_addr, mem_wdata=d_wdata, mem_rw=1, d_gnt=1, d_ack=1, all in the same cycle.
  - Stays in IDLE.
- Sub-word store (d_be not 4'b1111 and not 0):
  - Grant cycle: d_gnt=1, mem_rw=0, mem_addr=d_addr. Latch the address, wdata and be. Latch merged = per byte lane i, be[i] ? wdata lane : mem_rdata lane. Go to RMW_WR.
  - RMW_WR (1 cycle): mem_addr=latched address, mem_wdata=merged, mem_rw=1, d_ack=1, busy=1, no grants. Return to IDLE.
- Store with d_be=0: granted, d_ack=1 in the grant cycle, mem_rw=0, no memory change.
- if_rvalid, d_rvalid and d_ack are single-cycle pulses. Responses are returned in grant order.
- Requesters may drop or keep req after gnt. A still-high req is treated as a new request.
- mem_rw is never high outside a full-word store grant or RMW_WR.
- Reset asserted during RMW_WR: the write is abandoned, no d_ack, and memory is unchanged by the pending merge.
- A request arriving during RMW_WR waits. Arbitration resumes in the following IDLE cycle.

Test Plan:
- Memory word 0x100 = 0x11223344. Load d_addr=0x100 -> d_gnt cycle N, d_rvalid cycle N+1 with d_rdata=0x11223344, mem_rw never 1.
- Word 0x200 = 0xAABBCCDD. Store d_addr=0x202, d_be=4'b0100, d_wdata=0x00EE0000 -> d_gnt cycle N; RMW_WR cycle N+1 with mem_rw=1, mem_wdata=0xAAEECCDD, d_ack=1, busy=1; later load returns 0xAAEECCDD.
- Full store 0xDEADBEEF to 0x300 with d_be=4'b1111 -> mem_rw=1 and d_ack=1 in the grant cycle; busy never 1.
- if_req and d_req both held high continuously with STARVE_LIMIT=4 -> grant sequence D,D,D,D,I,D,D,D,D,I.
- if_req raised in the grant cycle of a sub-word store -> if_gnt withheld during RMW_WR, asserted the next cycle; if_rvalid one cycle after that.
- Reset pulsed mid-cycle during RMW_WR of a store of 0x000000FF, d_be=4'b0001, to a word holding 0x12345678 -> outputs zero immediately, no d_ack, word still 0x12345678.
